// File: rtl/tx_buf_fifo.sv
// ---------------------------------------------------------------------------
// tx_buf_fifo
// Circular transmit FIFO of DEPTH words x WIDTH bits sitting between the
// upstream producer and the serialiser. Provides registered read data with a
// valid strobe, occupancy-derived status, and sticky overflow/underflow flags.
//
// Ports
//   tClk      in   clock, rising edge
//   tRst      in   asynchronous active-low reset
//   tWR       in   write request
//   tdataIn   in   write data (WIDTH)
//   tRD       in   read (pop) request
//   tdataOut  out  registered read data (WIDTH)
//   tRdValid  out  one-cycle pulse qualifying tdataOut
//   tEMPTY    out  occupancy == 0
//   tFULL     out  occupancy == DEPTH
//   tAFULL    out  occupancy >= AF_LEVEL
//   tCount    out  occupancy (CW bits)
//   tOVF      out  sticky write-when-full error
//   tUNF      out  sticky read-when-empty error
//   tErrClr   in   synchronous clear of tOVF / tUNF (set wins)
//   ttxrdy    out  buffer ready, high from first edge after reset release
// ---------------------------------------------------------------------------
module tx_buf_fifo #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = 14,
   localparam int CW      = $clog2(DEPTH) + 1
) (
   input  logic             tClk,
   input  logic             tRst,
   input  logic             tWR,
   input  logic [WIDTH-1:0] tdataIn,
   input  logic             tRD,
   output logic [WIDTH-1:0] tdataOut,
   output logic             tRdValid,
   output logic             tEMPTY,
   output logic             tFULL,
   output logic             tAFULL,
   output logic [CW-1:0]    tCount,
   output logic             tOVF,
   output logic             tUNF,
   input  logic             tErrClr,
   output logic             ttxrdy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wp;
   logic [AW-1:0]    r_rp;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_dout;
   logic             r_vld;
   logic             r_ovf;
   logic             r_unf;
   logic             r_rdy;

   logic             w_rd_acc;
   logic             w_wr_acc;

   // Accept decodes use the pre-edge count; a write into a full FIFO is
   // allowed only when a pop frees a slot in the same cycle.
   always_comb begin
      w_rd_acc = 1'b0;
      w_wr_acc = 1'b0;
      if (tRD && (r_cnt != {CW{1'b0}})) begin
         w_rd_acc = 1'b1;
      end else begin
         w_rd_acc = 1'b0;
      end
      if (tWR && ((r_cnt != DEPTH_C) || w_rd_acc)) begin
         w_wr_acc = 1'b1;
      end else begin
         w_wr_acc = 1'b0;
      end
   end

   // Storage array; contents are intentionally not reset.
   always_ff @(posedge tClk) begin
      if (w_wr_acc) begin
         r_mem[r_wp] <= tdataIn;
      end
   end

   // Pointers, count, read data path, error flags and ready.
   always_ff @(posedge tClk or negedge tRst) begin
      if (!tRst) begin
         r_wp   <= {AW{1'b0}};
         r_rp   <= {AW{1'b0}};
         r_cnt  <= {CW{1'b0}};
         r_dout <= {WIDTH{1'b0}};
         r_vld  <= 1'b0;
         r_ovf  <= 1'b0;
         r_unf  <= 1'b0;
         r_rdy  <= 1'b0;
      end else begin
         r_rdy <= 1'b1;

         if (w_wr_acc) begin
            r_wp <= r_wp + AW'(1);
         end

         // Read data holds its last value when no pop is accepted.
         if (w_rd_acc) begin
            r_rp   <= r_rp + AW'(1);
            r_dout <= r_mem[r_rp];
            r_vld  <= 1'b1;
         end else begin
            r_vld  <= 1'b0;
         end

         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase

         // Set has priority over clear for both sticky flags.
         if (tWR && !w_wr_acc) begin
            r_ovf <= 1'b1;
         end else if (tErrClr) begin
            r_ovf <= 1'b0;
         end

         if (tRD && (r_cnt == {CW{1'b0}})) begin
            r_unf <= 1'b1;
         end else if (tErrClr) begin
            r_unf <= 1'b0;
         end
      end
   end

   assign tdataOut = r_dout;
   assign tRdValid = r_vld;
   assign tOVF     = r_ovf;
   assign tUNF     = r_unf;
   assign ttxrdy   = r_rdy;
   assign tCount   = r_cnt;
   assign tEMPTY   = (r_cnt == {CW{1'b0}});
   assign tFULL    = (r_cnt == DEPTH_C);
   assign tAFULL   = (r_cnt >= AF_C);

endmodule

// File: tb/tb_tx_buf_fifo.sv
// ---------------------------------------------------------------------------
// Testbench for tx_buf_fifo (default parameters: WIDTH 8, DEPTH 16, AF 14).
// A queue-based reference model predicts acceptance, occupancy, status and
// error flags; expected read words go into a scoreboard queue that a separate
// monitor drains whenever tRdValid is seen.
// ---------------------------------------------------------------------------
module tb_tx_buf_fifo;

   localparam int WIDTH    = 8;
   localparam int DEPTH    = 16;
   localparam int AF_LEVEL = 14;
   localparam int CW       = $clog2(DEPTH) + 1;

   logic             tClk = 1'b0;
   logic             tRst = 1'b0;
   logic             tWR = 1'b0;
   logic [WIDTH-1:0] tdataIn = '0;
   logic             tRD = 1'b0;
   logic             tErrClr = 1'b0;
   logic [WIDTH-1:0] tdataOut;
   logic             tRdValid;
   logic             tEMPTY;
   logic             tFULL;
   logic             tAFULL;
   logic [CW-1:0]    tCount;
   logic             tOVF;
   logic             tUNF;
   logic             ttxrdy;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [WIDTH-1:0] model_q[$];
   logic [WIDTH-1:0] exp_q[$];
   bit               m_ovf = 1'b0;
   bit               m_unf = 1'b0;

   tx_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
      .tClk(tClk), .tRst(tRst), .tWR(tWR), .tdataIn(tdataIn), .tRD(tRD),
      .tdataOut(tdataOut), .tRdValid(tRdValid), .tEMPTY(tEMPTY),
      .tFULL(tFULL), .tAFULL(tAFULL), .tCount(tCount), .tOVF(tOVF),
      .tUNF(tUNF), .tErrClr(tErrClr), .ttxrdy(ttxrdy)
   );

   always #5 tClk = ~tClk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every valid pulse must match the oldest expected word.
   always @(negedge tClk) begin
      if (tRst && tRdValid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_data: got %0h with no word expected at %0t", tdataOut, $time);
         end else begin
            chk("rd_data", int'(tdataOut), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic check_status(input bit exp_vld);
      int n;
      n = model_q.size();
      chk("count",   int'(tCount),   n);
      chk("empty",   int'(tEMPTY),   int'(n == 0));
      chk("full",    int'(tFULL),    int'(n == DEPTH));
      chk("afull",   int'(tAFULL),   int'(n >= AF_LEVEL));
      chk("ovf",     int'(tOVF),     int'(m_ovf));
      chk("unf",     int'(tUNF),     int'(m_unf));
      chk("rdvalid", int'(tRdValid), int'(exp_vld));
      chk("txrdy",   int'(ttxrdy),   1);
   endtask

   // One clock of stimulus with model update and post-edge status check.
   task automatic cycle(input bit wr, input bit rd, input logic [WIDTH-1:0] d, input bit clr);
      bit rd_acc, wr_acc, was_empty;
      @(negedge tClk);
      tWR = wr; tRD = rd; tdataIn = d; tErrClr = clr;
      was_empty = (model_q.size() == 0);
      rd_acc = rd && !was_empty;
      wr_acc = wr && ((model_q.size() < DEPTH) || rd_acc);
      if (rd_acc) exp_q.push_back(model_q.pop_front());
      if (wr_acc) model_q.push_back(d);
      if (wr && !wr_acc) m_ovf = 1'b1;
      else if (clr)      m_ovf = 1'b0;
      if (rd && was_empty) m_unf = 1'b1;
      else if (clr)        m_unf = 1'b0;
      @(posedge tClk);
      #1;
      check_status(rd_acc);
   endtask

   // Asynchronous reset in the middle of a cycle, then release at negedge.
   task automatic do_reset();
      #1;
      tWR = 1'b0; tRD = 1'b0; tErrClr = 1'b0;
      tRst = 1'b0;
      #1;
      chk("rst_count",   int'(tCount),   0);
      chk("rst_empty",   int'(tEMPTY),   1);
      chk("rst_full",    int'(tFULL),    0);
      chk("rst_afull",   int'(tAFULL),   0);
      chk("rst_rdvalid", int'(tRdValid), 0);
      chk("rst_dout",    int'(tdataOut), 0);
      chk("rst_ovf",     int'(tOVF),     0);
      chk("rst_unf",     int'(tUNF),     0);
      chk("rst_txrdy",   int'(ttxrdy),   0);
      model_q.delete();
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      @(negedge tClk);
      tRst = 1'b1;
      #1;
      chk("txrdy_before_edge", int'(ttxrdy), 0);
   endtask

   initial begin
      bit wr, rd;
      // power-on reset values
      #2;
      chk("por_count", int'(tCount), 0);
      chk("por_empty", int'(tEMPTY), 1);
      chk("por_txrdy", int'(ttxrdy), 0);
      @(negedge tClk);
      tRst = 1'b1;

      // mid-traffic reset with 5 words queued and a read in flight
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, WIDTH'(8'hE0 + i), 1'b0);
      cycle(1'b0, 1'b1, '0, 1'b0);
      chk("pre_rst_count", int'(tCount), 5);
      do_reset();
      cycle(1'b0, 1'b1, '0, 1'b0);           // rejected read, tUNF sets
      chk("unf_after_rst", int'(tUNF), 1);
      cycle(1'b0, 1'b0, '0, 1'b1);

      // fill 0x00..0x0F, overflow with 0xAA, then clear
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, WIDTH'(i), 1'b0);
      cycle(1'b1, 1'b0, 8'hAA, 1'b0);
      chk("ovf_set", int'(tOVF), 1);
      cycle(1'b0, 1'b0, '0, 1'b1);
      chk("ovf_clr", int'(tOVF), 0);

      // simultaneous read/write while full
      cycle(1'b1, 1'b1, 8'h55, 1'b0);
      chk("full_rw_count", int'(tCount), DEPTH);
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, '0, 1'b0);
      chk("drained_empty", int'(tEMPTY), 1);

      // simultaneous read/write while empty
      cycle(1'b1, 1'b1, 8'h3C, 1'b0);
      chk("empty_rw_unf", int'(tUNF), 1);
      cycle(1'b0, 1'b1, '0, 1'b1);
      cycle(1'b0, 1'b0, '0, 1'b0);

      // wrap-around with occupancy held in 3..10
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, WIDTH'($urandom), 1'b0);
      for (int i = 0; i < 40; i++) begin
         wr = (model_q.size() < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
         rd = (model_q.size() > 3)  ? 1'($urandom_range(0, 1)) : 1'b0;
         cycle(wr, rd, WIDTH'($urandom), 1'b0);
      end

      // unconstrained random traffic including error cases
      for (int i = 0; i < 300; i++) begin
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               WIDTH'($urandom), ($urandom_range(0, 7) == 0));
      end
      while (model_q.size() > 0) cycle(1'b0, 1'b1, '0, 1'b0);
      cycle(1'b0, 1'b0, '0, 1'b0);
      @(negedge tClk);
      #1;
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard time limit so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
